// File: rtl/n_bit_alu_pipe.sv
// n_bit_alu_pipe: a two-stage pipelined N-bit ALU with a valid/ready handshake
// on both sides, an accumulator that can replace operand A, and a sticky
// signed-overflow flag.
//   S1 holds the accepted request.
//   S2 holds the computed result and flags until downstream takes them.
// The ALU sits between the two stages. It reads the accumulator on the same
// edge that writes it, so back-to-back accumulator ops need no bubble.
module n_bit_alu_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic [2:0]   c,
  input  logic         acc_sel,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] f_out,
  output logic         c_out,
  output logic         V,
  output logic         Z,
  output logic         Neg,
  output logic [N-1:0] acc,
  output logic         V_sticky
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_OR   = 3'b010,
    OP_ORN  = 3'b011,
    OP_AND  = 3'b100,
    OP_ANDN = 3'b101,
    OP_NOTA = 3'b110,
    OP_NOTB = 3'b111
  } op_e;

  // Stage 1 request registers.
  logic         s1_valid;
  logic [N-1:0] s1_a;
  logic [N-1:0] s1_b;
  logic         s1_cin;
  op_e          s1_op;
  logic         s1_acc_sel;

  // Handshake terms.
  logic s1_advance;
  logic accept;

  // Combinational ALU outputs, computed from the S1 contents.
  logic [N-1:0] op_a;
  logic [N-1:0] b_eff;
  logic [N:0]   sum;
  logic         carry_msb;
  logic [N-1:0] res_f;
  logic         res_cout;
  logic         res_v;

  // S1 moves forward when S2 is empty or when S2 is emptying this same cycle.
  assign s1_advance = s1_valid && (!out_valid || out_ready);
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = in_valid && in_ready;

  // ALU: the adder always runs, so carry and overflow exist for every op.
  // NOTE: every signal written in always_comb gets a default first.
  // Otherwise a path that skips the assignment would infer a latch.
  always_comb begin
    op_a      = s1_acc_sel ? acc : s1_a;
    b_eff     = s1_op[0] ? ~s1_b : s1_b;
    sum       = {1'b0, op_a} + {1'b0, b_eff} + {{N{1'b0}}, s1_cin};
    // The carry into the MSB equals the MSB sum bit XOR both MSB addend bits.
    carry_msb = sum[N-1] ^ op_a[N-1] ^ b_eff[N-1];
    res_cout  = sum[N];
    res_v     = carry_msb ^ sum[N];
    res_f     = '0;
    unique case (s1_op)
      OP_ADD,
      OP_SUB:  res_f = sum[N-1:0];
      OP_OR:   res_f = op_a | s1_b;
      OP_ORN:  res_f = op_a | ~s1_b;
      OP_AND:  res_f = op_a & s1_b;
      OP_ANDN: res_f = op_a & ~s1_b;
      OP_NOTA: res_f = ~op_a;
      OP_NOTB: res_f = ~s1_b;
      default: res_f = '0;
    endcase
  end

  // Stage 1: capture a request on every accepted handshake.
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_cin     <= 1'b0;
      s1_op      <= OP_ADD;
      s1_acc_sel <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_a       <= a;
        s1_b       <= b;
        s1_cin     <= c_in;
        s1_op      <= op_e'(c);
        s1_acc_sel <= acc_sel;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: load the ALU result on transfer; hold it stable while stalled.
  // NOTE: the data registers are reset as well as the valid bit. f_out and the
  // flags are required to read zero during reset, not just be ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      f_out     <= '0;
      c_out     <= 1'b0;
      V         <= 1'b0;
      Z         <= 1'b0;
      Neg       <= 1'b0;
    end else begin
      if (s1_advance) begin
        out_valid <= 1'b1;
        f_out     <= res_f;
        c_out     <= res_cout;
        V         <= res_v;
        Z         <= (res_f == '0);
        Neg       <= res_f[N-1];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Accumulator and sticky overflow. A clear wins over a same-cycle transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      V_sticky <= 1'b0;
    end else if (acc_clr) begin
      acc      <= '0;
      V_sticky <= 1'b0;
    end else if (s1_advance) begin
      acc <= res_f;
      if (res_v) V_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_n_bit_alu_pipe.sv
// tb_n_bit_alu_pipe: directed test of n_bit_alu_pipe with N=8.
// Part one applies a table of single operations and checks the exact
// two-cycle latency, the result, the flags and the accumulator.
// The hand-written sequences that follow cover backpressure, accumulator
// chaining, a clear that coincides with a transfer, and reset mid-flight.
module tb_n_bit_alu_pipe;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic [2:0]   c;
  logic         acc_sel;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] f_out;
  logic         c_out;
  logic         V;
  logic         Z;
  logic         Neg;
  logic [N-1:0] acc;
  logic         V_sticky;

  int n_vec = 0;
  int n_err = 0;

  n_bit_alu_pipe #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .c        (c),
    .acc_sel  (acc_sel),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f_out    (f_out),
    .c_out    (c_out),
    .V        (V),
    .Z        (Z),
    .Neg      (Neg),
    .acc      (acc),
    .V_sticky (V_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] va;
    logic [N-1:0] vb;
    logic         cin;
    logic [N-1:0] f;
    logic         co;
    logic         v;
    logic         z;
    logic         ng;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one request at the negedge and hold it until an edge accepts it.
  task automatic send(input logic [2:0] op, input logic [N-1:0] va, input logic [N-1:0] vb,
                      input logic cin, input logic sel);
    int budget;
    @(negedge clk);
    c = op; a = va; b = vb; c_in = cin; acc_sel = sel; in_valid = 1'b1;
    budget = 0;
    #1;
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (budget >= 20) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  logic [N-1:0] exp_q[$];
  logic [N-1:0] held_f;
  int           delivered;
  int           stale;
  bit           will_acc;

  initial begin
    // Table columns: op, a, b, c_in, then expected f, c_out, V, Z, Neg.
    vecs[0]  = '{3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{3'b001, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'b110, 8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'b001, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'b010, 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{3'b011, 8'hF0, 8'h0F, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{3'b100, 8'h3C, 8'h0F, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b101, 8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{3'b111, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{3'b100, 8'hC0, 8'h40, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b000, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{3'b001, 8'h00, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; c = 3'b000;
    acc_sel = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

    // Reset state.
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", {f_out, c_out, V, Z, Neg}, 0);
    check("rst_acc", acc, 0);
    check("rst_v_sticky", V_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);

    // Table: each op alone, exact latency, result, flags, accumulator.
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].cin, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_early_valid", i), out_valid, 0);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), out_valid, 1);
      check($sformatf("v%0d_f", i), f_out, vecs[i].f);
      check($sformatf("v%0d_flags", i), {c_out, V, Z, Neg},
            {vecs[i].co, vecs[i].v, vecs[i].z, vecs[i].ng});
      check($sformatf("v%0d_acc", i), acc, vecs[i].f);
    end
    check("table_v_sticky", V_sticky, 1);

    // Backpressure: three back-to-back requests while downstream stalls.
    @(negedge clk);
    out_ready = 1'b0;
    exp_q = {8'h11, 8'h21, 8'h31};
    send(3'b000, 8'h10, 8'h01, 1'b0, 1'b0);
    send(3'b000, 8'h20, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    c = 3'b000; a = 8'h30; b = 8'h01; c_in = 1'b0; in_valid = 1'b1;
    #1;
    check("bp_in_ready_low", in_ready, 0);
    held_f = f_out;
    check("bp_first_f", held_f, 8'h11);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("bp_stall%0d_in_ready", k), in_ready, 0);
      check($sformatf("bp_stall%0d_f", k), f_out, held_f);
      check($sformatf("bp_stall%0d_valid", k), out_valid, 1);
    end
    out_ready = 1'b1;
    delivered = 0;
    for (int k = 0; k < 12 && delivered < 3; k++) begin
      #1;
      will_acc = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("bp_order%0d", delivered), f_out, exp_q[delivered]);
        delivered++;
      end
      @(posedge clk);
      #1 if (will_acc) in_valid = 1'b0;
      @(negedge clk);
    end
    check("bp_delivered", delivered, 3);
    // After the drain the pipeline must be empty: nothing duplicated.
    #1 check("bp_no_dup", out_valid, 0);

    // Accumulator chain: clear, then three back-to-back acc+0x10.
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    check("clr_acc", acc, 0);
    check("clr_v_sticky", V_sticky, 0);
    exp_q = {8'h10, 8'h20, 8'h30};
    c = 3'b000; a = 8'hEE; b = 8'h10; c_in = 1'b0; acc_sel = 1'b1; in_valid = 1'b1;
    delivered = 0;
    for (int k = 0; k < 12 && delivered < 3; k++) begin
      if (k == 3) in_valid = 1'b0;
      #1;
      if (out_valid) begin
        check($sformatf("chain%0d_f", delivered), f_out, exp_q[delivered]);
        delivered++;
      end
      @(negedge clk);
    end
    check("chain_delivered", delivered, 3);
    check("chain_acc", acc, 8'h30);
    acc_sel = 1'b0;

    // Clear coinciding with a transfer: clear wins, result still delivered.
    send(3'b000, 8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_clr_v_sticky", V_sticky, 1);
    check("pre_clr_acc", acc, 8'h80);
    send(3'b000, 8'hFF, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    check("cc_valid", out_valid, 1);
    check("cc_f", f_out, 8'h00);
    check("cc_cout", c_out, 1);
    check("cc_acc", acc, 0);
    check("cc_v_sticky", V_sticky, 0);

    // Reset with two requests in flight.
    @(negedge clk);
    send(3'b000, 8'h01, 8'h01, 1'b0, 1'b0);
    send(3'b000, 8'h02, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_valid_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_acc", acc, 0);
    check("mid_rst_f", f_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("mid_no_stale", stale, 0);
    send(3'b000, 8'h21, 8'h12, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_f", f_out, 8'h34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
